// File: rtl/matrix_pkg.sv
// matrix_pkg: shared widths and loader state encoding for the 2x2 matrix datapath
package matrix_pkg;
  localparam int ELEM_W = 8;
  localparam int N_ELEM = 4;
  localparam int MAT_W = 4 * ELEM_W;
  typedef enum logic [1:0] {LOAD_A = 2'd0, LOAD_B = 2'd1, PRESENT = 2'd2} state_t;
endpackage

// File: rtl/matrix2x2_operand_loader.sv
// matrix2x2_operand_loader: packs serial elements into two 2x2 operands and presents them as a pair
module matrix2x2_operand_loader
  import matrix_pkg::*;
#(
  parameter int ELEM_W = matrix_pkg::ELEM_W,
  parameter int N_ELEM = matrix_pkg::N_ELEM
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic [ELEM_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [4*ELEM_W-1:0] out_a,
  output logic [4*ELEM_W-1:0] out_b,
  output logic                out_valid,
  input  logic                out_ready
);
  state_t state, state_n;
  logic [1:0] idx;
  logic accept, last;
  assign in_ready = state != PRESENT;
  assign out_valid = state == PRESENT;
  assign accept = in_valid && in_ready;
  assign last = accept && idx == 2'd3;
  // next state: clear wins, then the fourth accept of a matrix, then the output handshake
  always_comb begin
    state_n = clear ? LOAD_A :
              last ? (state == LOAD_A ? LOAD_B : PRESENT) :
              (out_valid && out_ready) ? LOAD_A : state;
  end
  // state, element index and staging registers; the staging registers double as the outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LOAD_A;
      idx <= '0;
      out_a <= '0;
      out_b <= '0;
    end else begin
      state <= state_n;
      idx <= clear ? 2'd0 : accept ? idx + 2'd1 : idx;
      if (!clear && accept && state == LOAD_A) out_a[(3 - int'(idx))*ELEM_W +: ELEM_W] <= in_data;
      if (!clear && accept && state == LOAD_B) out_b[(3 - int'(idx))*ELEM_W +: ELEM_W] <= in_data;
    end
  end
endmodule

// File: tb/tb_matrix2x2_operand_loader.sv
// tb_matrix2x2_operand_loader: table vectors, corner sequences and random traffic against a pair-level model
module tb_matrix2x2_operand_loader;
  logic clk = 0, rst = 0, clear = 0, in_valid = 0, out_ready = 0;
  logic [7:0] in_data = 0;
  logic in_ready, out_valid;
  logic [31:0] out_a, out_b;
  int checks = 0, failures = 0;
  int cnt = 0;
  bit pres = 0;
  logic [31:0] ma = 0, mb = 0;

  typedef struct {
    logic v;
    logic [7:0] d;
    logic ordy;
    logic cl;
    logic e_ir;
    logic e_ov;
    logic [31:0] e_a;
    logic [31:0] e_b;
  } vec_t;
  vec_t tbl [9];

  matrix2x2_operand_loader dut (
    .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_a(out_a), .out_b(out_b), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model: a pair is eight accepted elements, first four fill A from the top byte down, next four fill B
  task automatic model_edge();
    if (clear) begin
      cnt = 0;
      pres = 0;
    end else if (pres) begin
      if (out_ready) pres = 0;
    end else if (in_valid) begin
      if (cnt < 4) ma[(3 - cnt)*8 +: 8] = in_data;
      else mb[(7 - cnt)*8 +: 8] = in_data;
      cnt++;
      if (cnt == 8) begin
        cnt = 0;
        pres = 1;
      end
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, !pres});
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, pres});
    chk({tag, ".out_a"}, out_a, ma);
    chk({tag, ".out_b"}, out_b, mb);
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic ordy, input logic cl, input string tag);
    in_valid = v;
    in_data = d;
    out_ready = ordy;
    clear = cl;
    model_edge();
    @(posedge clk);
    #1;
    cmp_model(tag);
  endtask

  initial begin
    tbl[0] = '{1, 8'h01, 1, 0, 1, 0, 32'h01000000, 32'h0};
    tbl[1] = '{1, 8'h02, 1, 0, 1, 0, 32'h01020000, 32'h0};
    tbl[2] = '{1, 8'h03, 1, 0, 1, 0, 32'h01020300, 32'h0};
    tbl[3] = '{1, 8'h04, 1, 0, 1, 0, 32'h01020304, 32'h0};
    tbl[4] = '{1, 8'h05, 1, 0, 1, 0, 32'h01020304, 32'h05000000};
    tbl[5] = '{1, 8'h06, 1, 0, 1, 0, 32'h01020304, 32'h05060000};
    tbl[6] = '{1, 8'h07, 1, 0, 1, 0, 32'h01020304, 32'h05060700};
    tbl[7] = '{1, 8'h08, 1, 0, 0, 1, 32'h01020304, 32'h05060708};
    tbl[8] = '{1, 8'h09, 1, 0, 1, 0, 32'h01020304, 32'h05060708};
    #1;
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset.out_a", out_a, 32'd0);
    chk("reset.out_b", out_b, 32'd0);
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 9; i++) begin
      in_valid = tbl[i].v;
      in_data = tbl[i].d;
      out_ready = tbl[i].ordy;
      clear = tbl[i].cl;
      model_edge();
      @(posedge clk);
      #1;
      chk("basic.in_ready", {31'd0, in_ready}, {31'd0, tbl[i].e_ir});
      chk("basic.out_valid", {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
      chk("basic.out_a", out_a, tbl[i].e_a);
      chk("basic.out_b", out_b, tbl[i].e_b);
    end
    for (int i = 0; i < 8; i++) step(1, 8'(i + 1), 0, 0, "bp_load");
    for (int i = 0; i < 5; i++) begin
      step(1, 8'h09, 0, 0, "bp_hold");
      chk("bp_hold.a", out_a, 32'h01020304);
    end
    step(1, 8'h09, 1, 0, "bp_release");
    step(1, 8'h09, 1, 0, "bp_next");
    chk("bp_next.a_top", {24'd0, out_a[31:24]}, 32'h09);
    step(0, 0, 0, 1, "flush");
    for (int i = 0; i < 16; i++) step(i % 2 == 0, 8'(i / 2 + 1), 0, 0, "bubble");
    chk("bubble.valid", {31'd0, out_valid}, 32'd1);
    chk("bubble.a", out_a, 32'h01020304);
    chk("bubble.b", out_b, 32'h05060708);
    step(0, 0, 1, 0, "bubble_drain");
    step(1, 8'hAA, 0, 0, "clr_pre");
    step(1, 8'hBB, 0, 0, "clr_pre");
    step(1, 8'hCC, 0, 0, "clr_pre");
    step(0, 0, 0, 1, "clr_pulse");
    for (int i = 0; i < 8; i++) step(1, 8'(8'h10 + i), 0, 0, "clr_load");
    chk("clr.a", out_a, 32'h10111213);
    chk("clr.b", out_b, 32'h14151617);
    step(0, 0, 1, 0, "clr_drain");
    step(1, 8'h55, 0, 1, "clr_coinc");
    chk("clr_coinc.a", out_a, 32'h10111213);
    for (int i = 0; i < 8; i++) step(1, 8'(8'h20 + i), 0, 0, "coinc_load");
    chk("coinc.a", out_a, 32'h20212223);
    chk("coinc.b", out_b, 32'h24252627);
    step(0, 0, 0, 1, "clr_present");
    chk("clr_present.a", out_a, 32'h20212223);
    for (int i = 0; i < 6; i++) step(1, 8'(8'h30 + i), 0, 0, "rst_pre");
    #3;
    rst = 0;
    #1;
    chk("arst.out_a", out_a, 32'd0);
    chk("arst.out_b", out_b, 32'd0);
    chk("arst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst.out_valid", {31'd0, out_valid}, 32'd0);
    cnt = 0;
    pres = 0;
    ma = 0;
    mb = 0;
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 8; i++) step(1, 8'(i + 1), 0, 0, "arst_load");
    chk("arst_load.a", out_a, 32'h01020304);
    chk("arst_load.b", out_b, 32'h05060708);
    step(0, 0, 1, 0, "arst_drain");
    for (int c = 0; c < 17; c++) begin
      step(1, 8'(c < 9 ? c + 1 : c), 1, 0, "b2b");
      if (c == 7) begin
        chk("b2b.p1a", out_a, 32'h01020304);
        chk("b2b.p1b", out_b, 32'h05060708);
        chk("b2b.idle", {31'd0, in_ready}, 32'd0);
      end
      if (c == 8) chk("b2b.resume", {31'd0, in_ready}, 32'd1);
    end
    chk("b2b.p2v", {31'd0, out_valid}, 32'd1);
    chk("b2b.p2a", out_a, 32'h090A0B0C);
    chk("b2b.p2b", out_b, 32'h0D0E0F10);
    for (int i = 0; i < 400; i++)
      step($urandom % 4 != 0, 8'($urandom), 1'($urandom), $urandom % 25 == 0, "rand");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/matrix2x2_operand_loader.md
# matrix2x2_operand_loader

Upstream feeder for the `matrix2x2Parallel` multiplier. It accepts 2x2 matrix elements serially, one element per cycle, over a valid/ready stream. It packs four elements into operand A, then four into operand B, and presents both packed operands together with a valid/ready handshake. The multiplier's `a`/`b` inputs connect directly to `out_a`/`out_b`.

## Interface
- `ELEM_W`, default 8: element width in bits.
- `N_ELEM`, default 4: elements per matrix. Fixed at 4 (2x2); other values are unsupported.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-low.
- `clear`  in  1: synchronous flush of the in-progress load.
- `in_data`  in  ELEM_W: element value.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: loader can accept an element.
- `out_a`  out  4*ELEM_W: packed matrix A.
- `out_b`  out  4*ELEM_W: packed matrix B.
- `out_valid`  out  1: `out_a`/`out_b` hold a complete operand pair.
- `out_ready`  in  1: multiplier consumes the pair.

## Operation
- State machine with three states:
  - LOAD_A: elements go to A.
  - LOAD_B: elements go to B.
  - PRESENT: pair is held.
- The reset state is LOAD_A.
- An element is accepted on a rising edge where `in_valid` and `in_ready` are both high.
- Element counter `idx` is 2 bits, reset to 0, and increments per accepted element.
- Accepted element `idx`=i is written to bits [(4-i)*ELEM_W-1 -: ELEM_W], so the first element lands in the MSB byte. Order is a11, a12, a21, a22.
- State transitions:
  - LOAD_A: at `idx`=3, the accept moves to LOAD_B, and `idx` wraps to 0.
  - LOAD_B: at `idx`=3, the accept moves to PRESENT.
  - PRESENT: a rising edge with `out_valid` and `out_ready` both high returns to LOAD_A, with `idx`=0.
- `in_ready` = (state != PRESENT), decoded directly from the state register. There are no input-side combinational paths.
- `out_valid` = (state == PRESENT).
- `out_a`/`out_b` are the staging registers themselves. They change only on accepted elements, so they are stable for the whole time `out_valid` is high.
- `in_valid` may drop at any time. Bubbles stall the load without losing position.
- `out_ready` is ignored outside PRESENT.
- `clear` high on an edge:
  - returns the FSM to LOAD_A with `idx`=0;
  - keeps the `out_a`/`out_b` contents (no zeroing);
  - in PRESENT, drops the pending pair.
- Simultaneous events:
  - `clear` has priority over an accept or an output handshake on the same edge; the element presented that cycle is discarded.
  - In PRESENT, `in_ready` is low, so an input transfer and an output handshake never coincide.
- Arithmetic: none. Elements are stored unmodified and are unsigned by convention.

## Timing
- Reset values, immediate on `rst` low:
  - `out_a`=0, `out_b`=0
  - `out_valid`=0, `in_ready`=1
  - state LOAD_A, `idx`=0
- Reset asserted mid-load or mid-present aborts everything.
- Latency: if the 8th element is accepted at edge k, `out_valid` is high in the cycle after edge k.
- After the output handshake at edge m, `in_ready`=1 in the cycle after edge m.
- Minimum period per pair is 9 cycles: 8 load cycles plus 1 present cycle, with `out_ready` tied high.
- `clear` takes effect at the edge where it is sampled.

## Structure
- Shared package `matrix_pkg`:
  - `ELEM_W` and `N_ELEM` defaults;
  - the state encoding (LOAD_A=2'd0, LOAD_B=2'd1, PRESENT=2'd2);
  - packed-matrix width `MAT_W` = 4*ELEM_W.
- The multiplier imports the same package, so its operand width matches.
- Single module; no sub-module warranted. The counter and FSM are small enough to stay inline.

## Test plan
- Basic load: stream 1..8 with `in_valid` high continuously and `out_ready`=1.
  - Response: `out_a`=0x01020304, `out_b`=0x05060708, `out_valid` high for exactly one cycle, arriving one cycle after the 8th accept.
- Backpressure: hold `out_ready`=0 for 5 cycles after the pair is presented, with `in_valid`=1 and `in_data`=9 throughout.
  - Response: `in_ready`=0, outputs unchanged, no element accepted. Raise `out_ready`; the next accepted element (9) lands in `out_a[31:24]`.
- Bubbles: send 1..8 with `in_valid` low on alternate cycles.
  - Response: same result as basic load; `out_valid` asserts after the 8th accepted element.
- Clear mid-load: accept 0xAA, 0xBB, 0xCC, pulse `clear`, then stream 0x10..0x17.
  - Response: `out_a`=0x10111213, `out_b`=0x14151617.
  - Also: `clear` coincident with an accept discards that element.
- Async reset mid-operation: assert `rst`=0 between clock edges during LOAD_B.
  - Response: outputs zero and `in_ready`=1 immediately. A following 8-element stream of 1..8 produces a correct pair.
- Back-to-back pairs: stream 16 elements (1..16) with `out_ready`=1.
  - Response: first pair 0x01020304/0x05060708, then 0x090A0B0C/0x0D0E0F10. Exactly one idle input cycle between them (the PRESENT cycle).
